// File: rtl/bcd_seg_scan_pkg.sv
// Shared types and segment constants for the multiplexed seven-segment scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_seg_scan_pkg;

   typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} slot_t;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

   localparam logic [3:0] AN_OFF = 4'b1111;

   function automatic logic [3:0] an_sel(input slot_t s);
      return ~(4'b0001 << s);
   endfunction

endpackage

// File: rtl/bcd_seg_scan_bcd_to_seg.sv
// BCD nibble to active-low seven-segment pattern; non-decimal nibbles show a dash.
module bcd_to_seg
   import bcd_seg_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (nibble)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_seg_scan.sv
// 4-digit common-anode display scanner with once-per-frame input capture,
// leading-zero blanking, anti-ghost guard and decimal-point control.
module bcd_seg_scan
   import bcd_seg_scan_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GUARD       = 16,
   parameter bit          BLANK_LZ    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] bcd_in,
   input  logic [3:0]  dp_in,
   input  logic        en,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

   logic [CNT_W-1:0] cnt;
   logic             tick;
   slot_t            idx, idx_next;
   logic [15:0]      frame;
   logic [3:0]       frame_dp;
   logic [3:0]       blank;
   logic [3:0]       nibble;
   logic             dp_cur;
   logic             blank_cur;
   logic [6:0]       seg_dec;

   assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt <= '0;
      else if (tick) cnt <= '0;
      else cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) idx <= DIG0;
      else idx <= idx_next;
   end

   always_comb begin
      idx_next = idx;
      if (tick) begin
         case (idx)
            DIG0: idx_next = DIG1;
            DIG1: idx_next = DIG2;
            DIG2: idx_next = DIG3;
            DIG3: idx_next = DIG0;
            default: idx_next = DIG0;
         endcase
      end
   end

   // Sampling only at the end of DIG3 keeps every scan frame coherent.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame    <= '0;
         frame_dp <= '0;
      end else if (tick && idx == DIG3) begin
         frame    <= bcd_in;
         frame_dp <= dp_in;
      end
   end

   // Each blank term chains on the one above, so a lit dp breaks the run of blanks.
   always_comb begin
      blank    = '0;
      blank[3] = BLANK_LZ && (frame[15:12] == 4'd0) && !frame_dp[3];
      blank[2] = blank[3] && (frame[11:8] == 4'd0) && !frame_dp[2];
      blank[1] = blank[2] && (frame[7:4] == 4'd0) && !frame_dp[1];
   end

   always_comb begin
      nibble    = frame[3:0];
      dp_cur    = frame_dp[0];
      blank_cur = blank[0];
      case (idx)
         DIG0: begin nibble = frame[3:0];   dp_cur = frame_dp[0]; blank_cur = blank[0]; end
         DIG1: begin nibble = frame[7:4];   dp_cur = frame_dp[1]; blank_cur = blank[1]; end
         DIG2: begin nibble = frame[11:8];  dp_cur = frame_dp[2]; blank_cur = blank[2]; end
         DIG3: begin nibble = frame[15:12]; dp_cur = frame_dp[3]; blank_cur = blank[3]; end
         default: ;
      endcase
   end

   bcd_to_seg u_dec (
      .nibble (nibble),
      .seg    (seg_dec)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an  <= AN_OFF;
         seg <= SEG_OFF;
         dp  <= 1'b1;
      end else begin
         an  <= (en && cnt >= CNT_W'(GUARD) && !blank_cur) ? an_sel(idx) : AN_OFF;
         seg <= seg_dec;
         dp  <= ~dp_cur;
      end
   end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan: stimulus queues per-cycle expectations,
// a negedge monitor compares both the blanking and non-blanking instances.
module tb_bcd_seg_scan;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;

   localparam logic [15:0] ALL_AN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

   typedef struct packed {
      logic [15:0] an;
      logic [27:0] seg;
      logic [3:0]  dp;
   } fexp_t;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  an;
      logic [3:0]  an_nb;
      logic [6:0]  seg;
      logic        dpv;
   } ent_t;

   localparam fexp_t F_Z    = '{an: {4'hF, 4'hF, 4'hF, 4'b1110}, seg: {S0, S0, S0, S0}, dp: 4'hF};
   localparam fexp_t F_1234 = '{an: ALL_AN, seg: {S1, S2, S3, S4}, dp: 4'hF};
   localparam fexp_t F_5678 = '{an: ALL_AN, seg: {S5, S6, S7, S8}, dp: 4'hF};
   localparam fexp_t F_0050 = '{an: {4'hF, 4'hF, 4'b1101, 4'b1110}, seg: {S0, S0, S5, S0}, dp: 4'hF};
   localparam fexp_t F_00A9 = '{an: {4'hF, 4'hF, 4'b1101, 4'b1110}, seg: {S0, S0, SD, S9}, dp: 4'hF};
   localparam fexp_t F_DP   = '{an: {4'hF, 4'b1011, 4'b1101, 4'b1110}, seg: {S0, S0, S0, S0}, dp: 4'b1011};
   localparam fexp_t F_9999 = '{an: ALL_AN, seg: {S9, S9, S9, S9}, dp: 4'hF};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] bcd_in = '0;
   logic [3:0]  dp_in = '0;
   logic        en = 1'b1;
   logic [6:0]  seg, seg_nb;
   logic        dp, dp_nb;
   logic [3:0]  an, an_nb;

   int          checks = 0;
   int          failures = 0;
   int unsigned stim_cyc = 0;
   int unsigned mon_cyc = 0;
   ent_t        q[$];
   ent_t        me;

   always #5 clk = ~clk;

   bcd_seg_scan #(.REFRESH_DIV(8), .GUARD(2), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .reset(reset), .bcd_in(bcd_in), .dp_in(dp_in), .en(en),
      .seg(seg), .dp(dp), .an(an)
   );

   bcd_seg_scan #(.REFRESH_DIV(8), .GUARD(2), .BLANK_LZ(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .bcd_in(bcd_in), .dp_in(dp_in), .en(en),
      .seg(seg_nb), .dp(dp_nb), .an(an_nb)
   );

   task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%b expected=%b", nm, mon_cyc, act, exp);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) mon_cyc <= 0;
      else mon_cyc <= mon_cyc + 1;
   end

   always @(negedge clk) begin
      if (!reset) begin
         while (q.size() > 0 && q[0].cyc <= mon_cyc) begin
            me = q.pop_front();
            if (me.cyc < mon_cyc) begin
               checks++;
               failures++;
               $display("FAIL missed cyc=%0d actual=none expected=entry", me.cyc);
            end else begin
               chk("out_lz", {an, seg, dp}, {me.an, me.seg, me.dpv});
               chk("out_nolz", {an_nb, seg_nb, dp_nb}, {me.an_nb, me.seg, me.dpv});
            end
         end
      end
   end

   // Inputs set just after a negedge take effect at the following posedge.
   task automatic step(input fexp_t fe, input logic en_v);
      ent_t        e;
      int unsigned n, pos, slot;
      logic        act;
      logic [15:0] all_an;
      all_an   = ALL_AN;
      en       = en_v;
      stim_cyc = stim_cyc + 1;
      n        = stim_cyc;
      pos      = (n - 1) % 8;
      slot     = ((n - 1) / 8) % 4;
      act      = en_v && (pos >= 2);
      e.cyc    = n;
      e.an     = act ? fe.an[slot*4 +: 4] : 4'hF;
      e.an_nb  = act ? all_an[slot*4 +: 4] : 4'hF;
      e.seg    = fe.seg[slot*7 +: 7];
      e.dpv    = fe.dp[slot];
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic run_frame(input fexp_t fe, input logic [15:0] a, input logic [15:0] b,
                            input int change_c, input logic [3:0] dpv,
                            input int en_lo, input int en_hi);
      for (int c = 0; c < 32; c++) begin
         bcd_in = (c < change_c) ? a : b;
         dp_in  = dpv;
         step(fe, !(c >= en_lo && c <= en_hi));
      end
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_lz"}, {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
      chk({nm, "_nolz"}, {an_nb, seg_nb, dp_nb}, {4'hF, 7'h7F, 1'b1});
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_reset("reset_init");
      reset = 1'b0;
      stim_cyc = 0;

      run_frame(F_Z,    16'h1234, 16'h1234, 0,  4'b0000, 99, 99);
      run_frame(F_1234, 16'h1234, 16'h5678, 11, 4'b0000, 99, 99);
      run_frame(F_5678, 16'h0050, 16'h0050, 0,  4'b0000, 99, 99);
      run_frame(F_0050, 16'h0000, 16'h0000, 0,  4'b0000, 99, 99);
      run_frame(F_Z,    16'h00A9, 16'h00A9, 0,  4'b0000, 99, 99);
      run_frame(F_00A9, 16'h0000, 16'h0000, 0,  4'b0100, 99, 99);
      run_frame(F_DP,   16'h1234, 16'h1234, 0,  4'b0000, 99, 99);
      run_frame(F_1234, 16'h1234, 16'h1234, 0,  4'b0000, 12, 23);

      for (int c = 0; c < 13; c++) begin
         bcd_in = 16'h1234;
         step(F_1234, 1'b1);
      end
      #2 reset = 1'b1;
      #1 chk_reset("reset_async");
      @(negedge clk);
      chk_reset("reset_hold");
      @(negedge clk);
      reset = 1'b0;
      stim_cyc = 0;

      run_frame(F_Z,    16'h9999, 16'h9999, 0, 4'b0000, 99, 99);
      run_frame(F_9999, 16'h0000, 16'h0000, 0, 4'b0000, 99, 99);

      #1;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain actual=%0d expected=0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
